// File: rtl/imm_extend_pipe_pkg.sv
// Shared encodings for immediate extension: mode codes used by the decode stage
// and the state codes of the two-entry skid buffer around the extender.
package imm_extend_pipe_pkg;

   localparam logic [1:0] MODE_SIGN   = 2'd0;
   localparam logic [1:0] MODE_ZERO   = 2'd1;
   localparam logic [1:0] MODE_UPPER  = 2'd2;
   localparam logic [1:0] MODE_BRANCH = 2'd3;

   localparam logic [1:0] ST_EMPTY = 2'd0;
   localparam logic [1:0] ST_ONE   = 2'd1;
   localparam logic [1:0] ST_TWO   = 2'd2;

endpackage

// File: rtl/imm_extend_pipe_core.sv
// Pure combinational immediate extender: SIGN, ZERO, UPPER and BRANCH forms of
// an IN_W-bit field into an OUT_W-bit result.
module imm_ext_core
   import imm_extend_pipe_pkg::*;
#(
   parameter int IN_W  = 16,
   parameter int OUT_W = 32
) (
   input  logic [IN_W-1:0]  data_i,
   input  logic [1:0]       mode_i,
   output logic [OUT_W-1:0] data_o
);

   logic [OUT_W-1:0] sign_ext;
   logic [OUT_W-1:0] zero_ext;
   logic [OUT_W-1:0] upper_ext;
   logic [OUT_W-1:0] branch_ext;

   assign sign_ext   = {{(OUT_W-IN_W){data_i[IN_W-1]}}, data_i};
   assign zero_ext   = {{(OUT_W-IN_W){1'b0}}, data_i};
   assign upper_ext  = {data_i, {(OUT_W-IN_W){1'b0}}};
   // The two dropped MSBs are copies of the sign bit since OUT_W >= IN_W+2.
   assign branch_ext = {sign_ext[OUT_W-3:0], 2'b00};

   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      data_o = sign_ext;
      case (mode_i)
         MODE_ZERO:   data_o = zero_ext;
         MODE_UPPER:  data_o = upper_ext;
         MODE_BRANCH: data_o = branch_ext;
         default:     data_o = sign_ext;
      endcase
   end

endmodule

// File: rtl/imm_extend_pipe.sv
// Registered immediate extender with valid/ready handshakes on both sides and a
// two-entry (output + skid) buffer so in_ready_o never depends on out_ready_i.
module imm_extend_pipe
   import imm_extend_pipe_pkg::*;
#(
   parameter int IN_W  = 16,
   parameter int OUT_W = 32
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [IN_W-1:0]  data_i,
   input  logic [1:0]       mode_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [OUT_W-1:0] data_o,
   output logic [1:0]       mode_o
);

   if (OUT_W < IN_W + 2) begin : g_bad_params
      $error("imm_extend_pipe: OUT_W must be at least IN_W+2");
   end

   logic [1:0]       state_q, state_d;
   logic [OUT_W-1:0] out_data_q, out_data_d;
   logic [1:0]       out_mode_q, out_mode_d;
   logic [OUT_W-1:0] skid_data_q, skid_data_d;
   logic [1:0]       skid_mode_q, skid_mode_d;
   logic [OUT_W-1:0] ext_data;
   logic             accept;
   logic             xfer;

   imm_ext_core #(
      .IN_W  (IN_W),
      .OUT_W (OUT_W)
   ) u_core (
      .data_i (data_i),
      .mode_i (mode_i),
      .data_o (ext_data)
   );

   // Both flags decode the state register only, so neither has a path from out_ready_i.
   assign in_ready_o  = (state_q != ST_TWO);
   assign out_valid_o = (state_q != ST_EMPTY);
   assign data_o      = out_data_q;
   assign mode_o      = out_mode_q;

   assign accept = in_valid_i & in_ready_o;
   assign xfer   = out_valid_o & out_ready_i;

   always_comb begin
      state_d     = state_q;
      out_data_d  = out_data_q;
      out_mode_d  = out_mode_q;
      skid_data_d = skid_data_q;
      skid_mode_d = skid_mode_q;
      case (state_q)
         ST_EMPTY: begin
            if (accept) begin
               out_data_d = ext_data;
               out_mode_d = mode_i;
               state_d    = ST_ONE;
            end
         end
         ST_ONE: begin
            if (accept && xfer) begin
               out_data_d = ext_data;
               out_mode_d = mode_i;
            end else if (accept) begin
               skid_data_d = ext_data;
               skid_mode_d = mode_i;
               state_d     = ST_TWO;
            end else if (xfer) begin
               state_d = ST_EMPTY;
            end
         end
         ST_TWO: begin
            if (xfer) begin
               out_data_d = skid_data_q;
               out_mode_d = skid_mode_q;
               state_d    = ST_ONE;
            end
         end
         default: state_d = ST_EMPTY;
      endcase
   end

   always_ff @(posedge clk_i) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      if (rst_i) begin
         // NOTE: the data registers are cleared too, not just the state, so data_o reads 0 after reset.
         state_q     <= ST_EMPTY;
         out_data_q  <= '0;
         out_mode_q  <= '0;
         skid_data_q <= '0;
         skid_mode_q <= '0;
      end else begin
         state_q     <= state_d;
         out_data_q  <= out_data_d;
         out_mode_q  <= out_mode_d;
         skid_data_q <= skid_data_d;
         skid_mode_q <= skid_mode_d;
      end
   end

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Directed bench for imm_extend_pipe: extension modes, backpressure, streaming
// against a queue model, reset while full, and a 12->64 bit instance.
module tb_imm_extend_pipe;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, in_ready, out_valid, out_ready;
   logic [15:0] din;
   logic [1:0]  min, mout;
   logic [31:0] dout;

   logic        in_valid2, in_ready2, out_valid2, out_ready2;
   logic [11:0] din2;
   logic [1:0]  min2, mout2;
   logic [63:0] dout2;

   int total = 0;
   int bad   = 0;

   logic [31:0] exp_data_q[$];
   logic [1:0]  exp_mode_q[$];
   int          sent, rcvd;

   always #5 clk = ~clk;

   imm_extend_pipe dut (
      .clk_i(clk), .rst_i(rst),
      .in_valid_i(in_valid), .in_ready_o(in_ready), .data_i(din), .mode_i(min),
      .out_valid_o(out_valid), .out_ready_i(out_ready), .data_o(dout), .mode_o(mout)
   );

   imm_extend_pipe #(.IN_W(12), .OUT_W(64)) dut2 (
      .clk_i(clk), .rst_i(rst),
      .in_valid_i(in_valid2), .in_ready_o(in_ready2), .data_i(din2), .mode_i(min2),
      .out_valid_o(out_valid2), .out_ready_i(out_ready2), .data_o(dout2), .mode_o(mout2)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] ref_ext(input logic [15:0] d, input logic [1:0] m);
      int s;
      s = int'($signed(d));
      case (m)
         2'd0:    return 32'(s);
         2'd1:    return {16'h0000, d};
         2'd2:    return {d, 16'h0000};
         default: return 32'(s * 4);
      endcase
   endfunction

   // One cycle of model bookkeeping: score a transfer, record an accept, advance.
   task automatic model_tick();
      if (out_valid && out_ready) begin
         if (exp_data_q.size() == 0) begin
            check($sformatf("spurious_out_%0d", rcvd), 64'(out_valid), 64'd0);
         end else begin
            check($sformatf("stream_data_%0d", rcvd), 64'(dout), 64'(exp_data_q.pop_front()));
            check($sformatf("stream_mode_%0d", rcvd), 64'(mout), 64'(exp_mode_q.pop_front()));
         end
         rcvd++;
      end
      if (in_valid && in_ready) begin
         exp_data_q.push_back(ref_ext(din, min));
         exp_mode_q.push_back(min);
         sent++;
      end
      step();
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; din = '0; min = '0;
      in_valid2 = 1'b0; out_ready2 = 1'b1; din2 = '0; min2 = '0;
      step(); step();
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_in_ready",  64'(in_ready),  64'd1);
      check("rst_data",      64'(dout),      64'd0);
      check("rst_mode",      64'(mout),      64'd0);
      check("rst_out_valid_w64", 64'(out_valid2), 64'd0);

      // Mode vectors, one per cycle with out_ready held high.
      rst = 1'b0;
      in_valid = 1'b1; din = 16'h8000; min = 2'd0;
      in_valid2 = 1'b1; din2 = 12'h800; min2 = 2'd0;
      step();
      check("sign_valid", 64'(out_valid), 64'd1);
      check("sign_data",  64'(dout), 64'hFFFF_8000);
      check("sign_mode",  64'(mout), 64'd0);
      check("sign_w64",   dout2, 64'hFFFF_FFFF_FFFF_F800);
      din = 16'hFFFE; min = 2'd1; min2 = 2'd1;
      step();
      check("zero_data", 64'(dout), 64'h0000_FFFE);
      check("zero_mode", 64'(mout), 64'd1);
      check("zero_w64",  dout2, 64'h0000_0000_0000_0800);
      min = 2'd2; min2 = 2'd2;
      step();
      check("upper_data", 64'(dout), 64'hFFFE_0000);
      check("upper_w64",  dout2, 64'h8000_0000_0000_0000);
      min = 2'd3; min2 = 2'd3;
      step();
      check("branch_data", 64'(dout), 64'hFFFF_FFF8);
      check("branch_mode", 64'(mout), 64'd3);
      check("branch_w64",  dout2, 64'hFFFF_FFFF_FFFF_E000);
      in_valid = 1'b0; in_valid2 = 1'b0;
      step();
      check("drain_empty", 64'(out_valid), 64'd0);

      // Backpressure: A then B fill OUT and SKID.
      out_ready = 1'b0;
      in_valid = 1'b1; din = 16'h0001; min = 2'd1;
      step();
      check("bp_a_valid", 64'(out_valid), 64'd1);
      check("bp_a_ready", 64'(in_ready), 64'd1);
      check("bp_a_data",  64'(dout), 64'h1);
      din = 16'h0002;
      step();
      check("bp_full_ready", 64'(in_ready), 64'd0);
      check("bp_full_data",  64'(dout), 64'h1);
      din = 16'h0003;
      step();
      check("bp_hold_ready", 64'(in_ready), 64'd0);
      check("bp_hold_data",  64'(dout), 64'h1);
      in_valid = 1'b0; out_ready = 1'b1;
      step();
      check("bp_b_data",  64'(dout), 64'h2);
      check("bp_b_valid", 64'(out_valid), 64'd1);
      check("bp_b_ready", 64'(in_ready), 64'd1);
      step();
      check("bp_done_empty", 64'(out_valid), 64'd0);

      // Streaming at full rate: no bubbles after the first cycle.
      sent = 0; rcvd = 0;
      for (int k = 0; k <= 100; k++) begin
         in_valid = (k < 100);
         din = 16'($urandom); min = 2'($urandom_range(0, 3));
         out_ready = 1'b1;
         if (k > 0) check($sformatf("stream_no_bubble_%0d", k), 64'(out_valid), 64'd1);
         if (k < 100) check($sformatf("stream_in_ready_%0d", k), 64'(in_ready), 64'd1);
         model_tick();
      end
      in_valid = 1'b0;
      for (int k = 0; k < 10 && rcvd < 100; k++) model_tick();
      check("stream_count", 64'(rcvd), 64'd100);

      // Random valid/ready against the model.
      sent = 0; rcvd = 0;
      for (int k = 0; k < 2000 && sent < 100; k++) begin
         in_valid = ($urandom_range(0, 3) != 0);
         din = 16'($urandom); min = 2'($urandom_range(0, 3));
         out_ready = ($urandom_range(0, 1) != 0);
         model_tick();
      end
      check("rand_sent", 64'(sent), 64'd100);
      in_valid = 1'b0; out_ready = 1'b1;
      for (int k = 0; k < 10 && rcvd < sent; k++) model_tick();
      check("rand_count", 64'(rcvd), 64'd100);
      check("rand_model_empty", 64'(exp_data_q.size()), 64'd0);

      // Reset while holding two items, with an input offered in the reset cycle.
      out_ready = 1'b0; in_valid = 1'b1; din = 16'h1234; min = 2'd1;
      step(); step();
      check("pre_rst_full", 64'(in_ready), 64'd0);
      rst = 1'b1;
      step();
      check("mid_rst_valid", 64'(out_valid), 64'd0);
      check("mid_rst_ready", 64'(in_ready), 64'd1);
      check("mid_rst_data",  64'(dout), 64'd0);
      // Reset from EMPTY with in_ready high: the offered item must be dropped.
      step();
      rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         step();
         check($sformatf("post_rst_no_stale_%0d", k), 64'(out_valid), 64'd0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
